// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and widths for the i2c request arbiter: FSM state encoding and i2c field widths.
package i2c_ctrl_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        XFER = 3'd1,
        GAP  = 3'd2,
        ERR  = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and master-side signal bundle of the i2c request arbiter.
// Handshake: a requester holds req_valid_in[i] plus its payload until req_ready_out[i]; the request is taken on
// the rising edge where both are high. Dropping valid before ready withdraws it. rsp_valid_out is a 1-cycle pulse.
interface i2c_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import i2c_ctrl_pkg::*;

    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr_in;
    logic [NUM_REQ*I2C_DATA_W-1:0] req_data_in;
    logic [NUM_REQ-1:0]            req_rd_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic [NUM_REQ-1:0]            rsp_valid_out;
    logic                          rsp_err_out;
    logic [I2C_DATA_W-1:0]         rsp_rdata_out;
    logic                          busy_out;
    logic [I2C_ADDR_W-1:0]         mst_addr_out;
    logic [I2C_DATA_W-1:0]         mst_data_out;
    logic                          mst_write_out;
    logic [I2C_DATA_W-1:0]         mst_read_data_in;
    state_t                        dbg_state_out;

    // Arbiter view.
    modport slave (
        input  req_valid_in, req_addr_in, req_data_in, req_rd_in, mst_read_data_in,
        output req_ready_out, rsp_valid_out, rsp_err_out, rsp_rdata_out, busy_out,
        output mst_addr_out, mst_data_out, mst_write_out, dbg_state_out
    );

    // Requester / i2c_master environment view.
    modport master (
        output req_valid_in, req_addr_in, req_data_in, req_rd_in, mst_read_data_in,
        input  req_ready_out, rsp_valid_out, rsp_err_out, rsp_rdata_out, busy_out,
        input  mst_addr_out, mst_data_out, mst_write_out, dbg_state_out
    );

endinterface

// File: rtl/i2c_req_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping past NUM_REQ-1 to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       any_o
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr_i} + (PTR_W + 1)'(off);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!any_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Time-shares one i2c_master between NUM_REQ requesters. The master has no done flag, so each transaction is a
// fixed XFER window (address driven) followed by a GAP window (address 0) before the read byte is sampled.
module i2c_req_arbiter
    import i2c_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int XFER_CYCLES = 20,
    parameter int GAP_CYCLES  = 2
) (
    input logic              clk_in,
    input logic              reset_in,
    i2c_req_arbiter_if.slave arb_if
);
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   XFER_LOAD = CNT_W'(XFER_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      idx_q;
    logic [I2C_ADDR_W-1:0] addr_q;
    logic [I2C_DATA_W-1:0] data_q;
    logic                  rd_q;
    logic [I2C_ADDR_W-1:0] mst_addr_q;
    logic                  busy_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic                  rsp_err_q;
    logic [I2C_DATA_W-1:0] rsp_rdata_q;

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_any;
    logic [I2C_ADDR_W-1:0] win_addr;
    logic [I2C_DATA_W-1:0] win_data;
    logic                  win_rd;
    logic [PTR_W-1:0]      ptr_d;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req_i      (arb_if.req_valid_in),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .grant_idx_o(win_idx),
        .any_o      (win_any)
    );

    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_rd   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_addr = arb_if.req_addr_in[i*I2C_ADDR_W +: I2C_ADDR_W];
                win_data = arb_if.req_data_in[i*I2C_DATA_W +: I2C_DATA_W];
                win_rd   = arb_if.req_rd_in[i];
            end
        end
    end

    assign ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Ready is only offered in IDLE, so a grant seen there is always an accept on the next edge.
    assign arb_if.req_ready_out = (state_q == IDLE) ? grant : '0;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rd_q        <= 1'b0;
            mst_addr_q  <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        addr_q <= win_addr;
                        data_q <= win_data;
                        rd_q   <= win_rd;
                        idx_q  <= win_idx;
                        ptr_q  <= ptr_d;
                        busy_q <= 1'b1;
                        if (win_addr == '0) begin
                            state_q <= ERR;
                            cnt_q   <= '0;
                        end else begin
                            state_q    <= XFER;
                            cnt_q      <= XFER_LOAD;
                            mst_addr_q <= win_addr;
                        end
                    end
                end
                XFER: begin
                    if (cnt_q == '0) begin
                        state_q    <= GAP;
                        cnt_q      <= GAP_LOAD;
                        mst_addr_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= ONE_HOT0 << idx_q;
                        rsp_rdata_q <= rd_q ? arb_if.mst_read_data_in : '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ERR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= ONE_HOT0 << idx_q;
                    rsp_err_q   <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arb_if.mst_addr_out  = mst_addr_q;
    assign arb_if.mst_data_out  = data_q;
    assign arb_if.mst_write_out = rd_q;
    assign arb_if.busy_out      = busy_q;
    assign arb_if.rsp_valid_out = rsp_valid_q;
    assign arb_if.rsp_err_out   = rsp_err_q;
    assign arb_if.rsp_rdata_out = rsp_rdata_q;
    assign arb_if.dbg_state_out = state_q;

endmodule
